sha1_digest_matcher: RTL

- Return-path partner of the candidate generator. The generator pads base-36 candidates into 512-bit blocks and sends them to the SHA-1 core; this block receives the digests the core returns.
- Holds the base-36 digits of every candidate in flight in a tag FIFO, in issue order. Each returned digest is paired with the oldest tag and compared against a 160-bit target.
- On a match it decodes the digits to ASCII and reports the cracked password. Otherwise it reports exhaustion once the last candidate has been checked.

---
 rtl/sha1_digest_matcher.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sha1_digest_matcher.sv
// Pairs SHA-1 digests returned by the core with the candidate tags issued to it,
// compares each against the target and reports the cracked password or exhaustion.
module sha1_digest_matcher #(
  parameter int DEPTH    = 4,
  parameter int DIGITS   = 4,
  parameter int DIGEST_W = 160
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIGEST_W-1:0]   target_digest,
  input  logic                  issue_valid,
  input  logic [6*DIGITS-1:0]   issue_digits,
  input  logic                  issue_last,
  output logic                  issue_ready,
  input  logic                  dig_valid,
  input  logic [DIGEST_W-1:0]   dig_data,
  output logic                  found,
  output logic                  done,
  output logic [8*DIGITS-1:0]   password,
  output logic [15:0]           checked_count,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 6 * DIGITS;
  localparam int PW = 8 * DIGITS;
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_END   = 2'd3
  } state_t;

  function automatic logic [7:0] digit_to_ascii(input logic [5:0] d);
    logic [7:0] a;
    if (d < 6'd10) a = 8'h30 + {2'b00, d};
    else if (d < 6'd36) a = 8'h61 + {2'b00, d} - 8'd10;
    else a = 8'h3F;
    return a;
  endfunction

  // Digit i and character i occupy matching positions, so a straight per-slice map keeps order.
  function automatic logic [PW-1:0] decode_tag(input logic [TW-1:0] t);
    logic [PW-1:0] o;
    o = {PW{1'b0}};
    for (int i = 0; i < DIGITS; i++) o[8*i +: 8] = digit_to_ascii(t[6*i +: 6]);
    return o;
  endfunction

  state_t              state_r, state_n;
  logic [TW-1:0]       mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r, wr_ptr_n, rd_ptr_r, rd_ptr_n;
  logic [AW:0]         count_r, count_n;
  logic [DIGEST_W-1:0] target_r;
  logic                found_r, found_n, done_r, done_n, err_r, err_n, ready_r, ready_n;
  logic [PW-1:0]       pw_r, pw_n;
  logic [15:0]         chk_r, chk_n;
  logic                push_s, pop_s, hit_s;

  // Next-state, FIFO bookkeeping and result updates.
  always_comb begin
    state_n  = state_r;
    wr_ptr_n = wr_ptr_r;
    rd_ptr_n = rd_ptr_r;
    count_n  = count_r;
    found_n  = found_r;
    done_n   = done_r;
    err_n    = err_r;
    pw_n     = pw_r;
    chk_n    = chk_r;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    hit_s    = 1'b0;
    if (start) begin
      state_n  = S_RUN;
      wr_ptr_n = PTR_ZERO;
      rd_ptr_n = PTR_ZERO;
      count_n  = CNT_ZERO;
      found_n  = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
      pw_n     = {PW{1'b0}};
      chk_n    = 16'd0;
    end else begin
      case (state_r)
        S_RUN, S_DRAIN: begin
          push_s = issue_valid && ready_r && (state_r == S_RUN);
          pop_s  = dig_valid && (count_r != CNT_ZERO);
          hit_s  = pop_s && (dig_data == target_r);
          if (push_s) wr_ptr_n = wr_ptr_r + PTR_ONE;
          else wr_ptr_n = wr_ptr_r;
          if (pop_s) begin
            rd_ptr_n = rd_ptr_r + PTR_ONE;
            if (chk_r != 16'hFFFF) chk_n = chk_r + 16'd1;
            else chk_n = chk_r;
          end else begin
            rd_ptr_n = rd_ptr_r;
          end
          if (push_s && !pop_s) count_n = count_r + CNT_ONE;
          else if (pop_s && !push_s) count_n = count_r - CNT_ONE;
          else count_n = count_r;
          if (dig_valid && (count_r == CNT_ZERO)) err_n = 1'b1;
          else err_n = err_r;
          if (hit_s) begin
            found_n  = 1'b1;
            done_n   = 1'b1;
            pw_n     = decode_tag(mem_r[rd_ptr_r]);
            wr_ptr_n = PTR_ZERO;
            rd_ptr_n = PTR_ZERO;
            count_n  = CNT_ZERO;
            state_n  = S_END;
          end else if (push_s && issue_last) begin
            state_n = S_DRAIN;
          end else if ((state_r == S_DRAIN) && pop_s && (count_r == CNT_ONE)) begin
            done_n  = 1'b1;
            state_n = S_END;
          end else begin
            state_n = state_r;
          end
        end
        default: state_n = state_r;
      endcase
    end
    ready_n = (state_n == S_RUN) && (count_n < CNT_FULL);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      target_r <= {DIGEST_W{1'b0}};
      found_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ready_r  <= 1'b0;
      pw_r     <= {PW{1'b0}};
      chk_r    <= 16'd0;
    end else begin
      state_r  <= state_n;
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      count_r  <= count_n;
      if (start) target_r <= target_digest;
      found_r  <= found_n;
      done_r   <= done_n;
      err_r    <= err_n;
      ready_r  <= ready_n;
      pw_r     <= pw_n;
      chk_r    <= chk_n;
    end
  end

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= issue_digits;
  end

  assign issue_ready   = ready_r;
  assign found         = found_r;
  assign done          = done_r;
  assign err           = err_r;
  assign password      = pw_r;
  assign checked_count = chk_r;

endmodule
